// File: rtl/ca_pkg.sv
// Shared definitions for elementary cellular-automaton controllers:
// array width, boundary modes and sequencer state encoding.
package ca_pkg;

    localparam int unsigned CA_WIDTH = 32;

    typedef enum logic [1:0] {
        BOUND_ZERO    = 2'd0,
        BOUND_ONE     = 2'd1,
        BOUND_WRAP    = 2'd2,
        BOUND_REFLECT = 2'd3
    } bound_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/ca_run_ctrl_if.sv
// Command and generation-stream handshake bundle of the CA run sequencer.
// The slave modport is the sequencer side; master is the host/consumer side.
interface ca_run_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_rule;
    logic [WIDTH-1:0] cmd_seed;
    logic [GEN_W-1:0] cmd_gens;
    logic [1:0]       cmd_bound;

    logic             gen_valid;
    logic             gen_ready;
    logic [WIDTH-1:0] gen_data;
    logic [GEN_W-1:0] gen_index;
    logic             gen_last;

    modport master (
        output cmd_valid, cmd_rule, cmd_seed, cmd_gens, cmd_bound, gen_ready,
        input  cmd_ready, gen_valid, gen_data, gen_index, gen_last
    );

    modport slave (
        input  cmd_valid, cmd_rule, cmd_seed, cmd_gens, cmd_bound, gen_ready,
        output cmd_ready, gen_valid, gen_data, gen_index, gen_last
    );
endinterface

// File: rtl/ca_boundary_mux.sv
// Edge-neighbour selection for a 1-D CA array: drives the virtual cells
// beyond cell 0 (left) and cell WIDTH-1 (right) from the boundary mode.
module ca_boundary_mux
    import ca_pkg::*;
#(
    parameter int unsigned WIDTH = CA_WIDTH
) (
    input  bound_e           bound_i,
    input  logic [WIDTH-1:0] ca_out_i,
    output logic             left_o,
    output logic             right_o
);

    always_comb begin
        left_o  = 1'b0;
        right_o = 1'b0;
        unique case (bound_i)
            BOUND_ZERO: begin
                left_o  = 1'b0;
                right_o = 1'b0;
            end
            BOUND_ONE: begin
                left_o  = 1'b1;
                right_o = 1'b1;
            end
            BOUND_WRAP: begin
                left_o  = ca_out_i[WIDTH-1];
                right_o = ca_out_i[0];
            end
            BOUND_REFLECT: begin
                left_o  = ca_out_i[0];
                right_o = ca_out_i[WIDTH-1];
            end
        endcase
    end

endmodule

// File: rtl/ca_run_ctrl.sv
// Run sequencer for the 32-cell CA array: loads a seed, steps one generation
// per accepted output beat and streams every generation with backpressure.
module ca_run_ctrl
    import ca_pkg::*;
#(
    parameter int unsigned WIDTH = CA_WIDTH,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ca_run_ctrl_if.slave     bus,
    input  logic             abort_i,
    output logic             busy_o,
    output logic [7:0]       ca_rule_o,
    output logic [WIDTH-1:0] ca_state_o,
    output logic             ca_set_state_o,
    output logic             ca_left_o,
    output logic             ca_right_o,
    input  logic [WIDTH-1:0] ca_out_i
);

    state_e           state_q, state_d;
    logic [7:0]       rule_q, rule_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [GEN_W-1:0] gens_q, gens_d;
    logic [GEN_W-1:0] idx_q, idx_d;
    bound_e           bound_q, bound_d;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rule_q  <= '0;
            seed_q  <= '0;
            gens_q  <= '0;
            idx_q   <= '0;
            bound_q <= BOUND_ZERO;
        end else begin
            state_q <= state_d;
            rule_q  <= rule_d;
            seed_q  <= seed_d;
            gens_q  <= gens_d;
            idx_q   <= idx_d;
            bound_q <= bound_d;
        end
    end

    assign last = (idx_q == gens_q);

    // The array has no enable: it is held by reloading its own outputs,
    // and only an accepted non-final beat lets it step.
    always_comb begin
        state_d        = state_q;
        rule_d         = rule_q;
        seed_d         = seed_q;
        gens_d         = gens_q;
        idx_d          = idx_q;
        bound_d        = bound_q;
        bus.cmd_ready  = 1'b0;
        bus.gen_valid  = 1'b0;
        ca_set_state_o = 1'b1;
        ca_state_o     = ca_out_i;

        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = !abort_i;
                if (bus.cmd_valid && !abort_i) begin
                    rule_d  = bus.cmd_rule;
                    seed_d  = bus.cmd_seed;
                    gens_d  = bus.cmd_gens;
                    bound_d = bound_e'(bus.cmd_bound);
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    ca_state_o = seed_q;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    bus.gen_valid = 1'b1;
                    if (bus.gen_ready) begin
                        if (last) begin
                            state_d = IDLE;
                        end else begin
                            ca_set_state_o = 1'b0;
                            idx_d          = idx_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gen_data  = ca_out_i;
    assign bus.gen_index = idx_q;
    assign bus.gen_last  = last;
    assign busy_o        = (state_q != IDLE);
    assign ca_rule_o     = rule_q;

    ca_boundary_mux #(
        .WIDTH(WIDTH)
    ) u_bound (
        .bound_i  (bound_q),
        .ca_out_i (ca_out_i),
        .left_o   (ca_left_o),
        .right_o  (ca_right_o)
    );

endmodule

// File: tb/tb_ca_run_ctrl.sv
// Directed bench for ca_run_ctrl with a behavioural 32-cell CA array model
// closing the load/step loop.
module tb_ca_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort_i;
    logic        busy_o;
    logic [7:0]  ca_rule_o;
    logic [31:0] ca_state_o;
    logic        ca_set_state_o;
    logic        ca_left_o;
    logic        ca_right_o;
    logic [31:0] cells = '0;

    int vecs = 0;
    int errs = 0;
    int hs   = 0;
    int hs0;

    ca_run_ctrl_if #(.WIDTH(32), .GEN_W(16)) bus ();

    ca_run_ctrl #(.WIDTH(32), .GEN_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .ca_rule_o      (ca_rule_o),
        .ca_state_o     (ca_state_o),
        .ca_set_state_o (ca_set_state_o),
        .ca_left_o      (ca_left_o),
        .ca_right_o     (ca_right_o),
        .ca_out_i       (cells)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ca_next(input logic [31:0] c, input logic [7:0] rule,
                                            input logic l, input logic r);
        logic [31:0] n;
        logic        lf, rt;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0) lf = l; else lf = c[i-1];
            if (i == 31) rt = r; else rt = c[i+1];
            n[i] = rule[{lf, c[i], rt}];
        end
        return n;
    endfunction

    // Array model: registered cells, load strobe has priority over stepping.
    always @(posedge clk) begin
        if (ca_set_state_o) cells <= ca_state_o;
        else                cells <= ca_next(cells, ca_rule_o, ca_left_o, ca_right_o);
    end

    always @(posedge clk) begin
        if (rst_n && bus.gen_valid && bus.gen_ready) hs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] r, input logic [31:0] s, input logic [15:0] g,
                        input logic [1:0] b);
        bus.cmd_rule  = r;
        bus.cmd_seed  = s;
        bus.cmd_gens  = g;
        bus.cmd_bound = b;
        bus.cmd_valid = 1'b1;
        #1;
        chk("accept_ready", {31'b0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        chk("load_busy", {31'b0, busy_o}, 32'd1);
        chk("load_valid", {31'b0, bus.gen_valid}, 32'd0);
        chk("load_state", ca_state_o, s);
        chk("load_strobe", {31'b0, ca_set_state_o}, 32'd1);
        tick();
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic [15:0] i,
                        input logic l);
        chk({tag, "_valid"}, {31'b0, bus.gen_valid}, 32'd1);
        chk({tag, "_data"}, bus.gen_data, d);
        chk({tag, "_index"}, {16'b0, bus.gen_index}, {16'b0, i});
        chk({tag, "_last"}, {31'b0, bus.gen_last}, {31'b0, l});
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        abort_i       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_rule  = '0;
        bus.cmd_seed  = '0;
        bus.cmd_gens  = '0;
        bus.cmd_bound = '0;
        bus.gen_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_valid", {31'b0, bus.gen_valid}, 32'd0);
        chk("rst_rule", {24'b0, ca_rule_o}, 32'd0);
        chk("rst_strobe", {31'b0, ca_set_state_o}, 32'd1);
        chk("rst_hold", ca_state_o, 32'h0);
        chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Rule 90 spreading from one cell, zero boundary.
        send(8'd90, 32'h0001_0000, 16'd2, 2'd0);
        beat("t1_g0", 32'h0001_0000, 16'd0, 1'b0);
        beat("t1_g1", 32'h0002_8000, 16'd1, 1'b0);
        beat("t1_g2", 32'h0004_4000, 16'd2, 1'b1);
        chk("t1_idle_busy", {31'b0, busy_o}, 32'd0);
        chk("t1_idle_valid", {31'b0, bus.gen_valid}, 32'd0);
        chk("t1_frozen", ca_state_o, 32'h0004_4000);
        chk("t1_rule", {24'b0, ca_rule_o}, 32'd90);

        // Wrap boundary feeds cell 0 into cell 31.
        send(8'd90, 32'h0000_0001, 16'd1, 2'd2);
        chk("t2w_left", {31'b0, ca_left_o}, 32'd0);
        chk("t2w_right", {31'b0, ca_right_o}, 32'd1);
        beat("t2w_g0", 32'h0000_0001, 16'd0, 1'b0);
        beat("t2w_g1", 32'h8000_0002, 16'd1, 1'b1);
        send(8'd90, 32'h0000_0001, 16'd1, 2'd0);
        beat("t2z_g0", 32'h0000_0001, 16'd0, 1'b0);
        beat("t2z_g1", 32'h0000_0002, 16'd1, 1'b1);

        // Ones boundary on an empty array.
        send(8'd90, 32'h0000_0000, 16'd1, 2'd1);
        chk("t3_left", {31'b0, ca_left_o}, 32'd1);
        chk("t3_right", {31'b0, ca_right_o}, 32'd1);
        beat("t3_g0", 32'h0000_0000, 16'd0, 1'b0);
        beat("t3_g1", 32'h8000_0001, 16'd1, 1'b1);

        // Reflect: left mirrors cell 0, right mirrors cell 31.
        send(8'd90, 32'h0000_0001, 16'd1, 2'd3);
        chk("tr_left", {31'b0, ca_left_o}, 32'd1);
        chk("tr_right", {31'b0, ca_right_o}, 32'd0);
        beat("tr_g0", 32'h0000_0001, 16'd0, 1'b0);
        beat("tr_g1", 32'h0000_0003, 16'd1, 1'b1);

        // Backpressure at index 1 for five cycles.
        hs0 = hs;
        send(8'd90, 32'h0001_0000, 16'd2, 2'd0);
        beat("t4_g0", 32'h0001_0000, 16'd0, 1'b0);
        bus.gen_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_stall_valid", {31'b0, bus.gen_valid}, 32'd1);
            chk("t4_stall_data", bus.gen_data, 32'h0002_8000);
            chk("t4_stall_index", {16'b0, bus.gen_index}, 32'd1);
            chk("t4_stall_strobe", {31'b0, ca_set_state_o}, 32'd1);
            tick();
        end
        bus.gen_ready = 1'b1;
        #1;
        beat("t4_g1", 32'h0002_8000, 16'd1, 1'b0);
        beat("t4_g2", 32'h0004_4000, 16'd2, 1'b1);
        chk("t4_beats", 32'(hs - hs0), 32'd3);
        chk("t4_done", {31'b0, bus.gen_valid}, 32'd0);

        // Zero-step run: seed only, flagged last.
        send(8'd30, 32'hDEAD_BEEF, 16'd0, 2'd0);
        beat("t5_g0", 32'hDEAD_BEEF, 16'd0, 1'b1);
        chk("t5_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("t5_busy", {31'b0, busy_o}, 32'd0);

        // Abort in IDLE blocks command acceptance.
        bus.cmd_valid = 1'b1;
        abort_i       = 1'b1;
        #1;
        chk("idle_abort_ready", {31'b0, bus.cmd_ready}, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        abort_i       = 1'b0;
        #1;
        chk("idle_abort_busy", {31'b0, busy_o}, 32'd0);

        // Abort at index 10 together with gen_ready.
        send(8'd90, 32'h0001_0000, 16'd100, 2'd0);
        for (int k = 0; k < 10; k++) begin
            chk("t6_index", {16'b0, bus.gen_index}, 32'(k));
            tick();
        end
        abort_i = 1'b1;
        #1;
        chk("t6_abort_index", {16'b0, bus.gen_index}, 32'd10);
        chk("t6_abort_valid", {31'b0, bus.gen_valid}, 32'd0);
        chk("t6_abort_strobe", {31'b0, ca_set_state_o}, 32'd1);
        hs0 = hs;
        tick();
        abort_i = 1'b0;
        #1;
        chk("t6_no_xfer", 32'(hs - hs0), 32'd0);
        chk("t6_busy", {31'b0, busy_o}, 32'd0);
        chk("t6_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        send(8'd150, 32'h0000_0001, 16'd1, 2'd0);
        chk("t6_new_rule", {24'b0, ca_rule_o}, 32'd150);
        beat("t6_g0", 32'h0000_0001, 16'd0, 1'b0);
        beat("t6_g1", 32'h0000_0003, 16'd1, 1'b1);

        // Asynchronous reset mid-run leaves the array untouched.
        send(8'd90, 32'h0000_0001, 16'd5, 2'd0);
        beat("ar_g0", 32'h0000_0001, 16'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'b0, busy_o}, 32'd0);
        chk("ar_valid", {31'b0, bus.gen_valid}, 32'd0);
        chk("ar_rule", {24'b0, ca_rule_o}, 32'd0);
        chk("ar_cells", ca_state_o, 32'h0000_0002);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_idle_ready", {31'b0, bus.cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ca_run_ctrl.md
Name: ca_run_ctrl

Overview:
- Sequencer for the 32-cell elementary cellular-automaton array.
- Accepts a run command (rule, seed, generation count, boundary mode) on a valid/ready interface.
- Loads the seed into the array and steps it one generation per accepted output beat.
- Streams every generation, seed first, on a valid/ready output with backpressure. The array has no enable, so the block freezes it by reloading its own output through the load path.

Parameters:
- WIDTH, 32, cell count of the array; only 32 is supported.
- GEN_W, 16, width of the generation count and generation index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  run command valid
- cmd_ready  out  1  run command accepted when high with cmd_valid
- cmd_rule  in  8  Wolfram rule number
- cmd_seed  in  WIDTH  initial generation
- cmd_gens  in  GEN_W  steps to run; cmd_gens+1 generations are emitted
- cmd_bound  in  2  boundary mode: 0 = zeros, 1 = ones, 2 = wrap, 3 = reflect
- abort  in  1  cancel the run in progress
- gen_valid  out  1  generation beat valid
- gen_ready  in  1  consumer ready
- gen_data  out  WIDTH  generation contents (bit i = cell i)
- gen_index  out  GEN_W  generation number, 0 = seed
- gen_last  out  1  final beat of the run
- busy  out  1  high in LOAD or RUN
- ca_rule  out  8  to the array rule input
- ca_state  out  WIDTH  to the array load data
- ca_set_state  out  1  to the array load strobe
- ca_left  out  1  left neighbour of cell 0
- ca_right  out  1  right neighbour of cell WIDTH-1
- ca_out  in  WIDTH  from the array cell outputs

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset values: state IDLE; rule_q, seed_q, gens_q, idx_q, bound_q all 0.
  - Derived outputs: gen_valid=0, busy=0, ca_rule=0, ca_set_state=1, ca_state=ca_out.
- IDLE:
  - cmd_ready = !abort.
  - On cmd_valid&&cmd_ready, latch rule/seed/gens/bound, clear idx_q, go to LOAD.
  - Array is frozen in IDLE (set_state=1, state=ca_out), so the last generation stays visible.
- LOAD (exactly 1 cycle):
  - ca_set_state=1, ca_state=seed_q, then go to RUN.
  - Latency: command accepted in cycle T, gen 0 is valid in cycle T+2.
- RUN:
  - gen_valid = !abort; gen_data = ca_out; gen_index = idx_q; gen_last = (idx_q == gens_q).
  - Handshake with !gen_last: ca_set_state=0, so the array steps on the same edge; idx_q++. Throughput is 1 generation per cycle.
  - Handshake with gen_last: array frozen, go to IDLE.
  - No handshake: ca_set_state=1, ca_state=ca_out (hold). gen_data must stay stable while valid and not ready.
  - gen_ready→ca_set_state is a permitted combinational path.
- ca_rule = rule_q at all times; it changes only when a command is accepted.
- Boundary, combinational from ca_out and bound_q:
  - zeros: left=0, right=0.
  - ones: left=1, right=1.
  - wrap: left=ca_out[31], right=ca_out[0].
  - reflect: left=ca_out[0], right=ca_out[31].
- abort:
  - In LOAD or RUN: gen_valid is forced 0 that cycle (no transfer counts), go to IDLE next edge, array frozen.
  - In IDLE: cmd_ready is low; otherwise abort has no effect.
  - abort wins over a simultaneous gen_ready.
- cmd_gens=0: a single beat (seed) with gen_last=1.
- cmd_gens=2^GEN_W-1: 65536 beats. idx_q compares by equality and never wraps inside a run.
- busy = (state != IDLE).
- Async reset mid-run: immediate return to IDLE with reset values; array contents are not cleared.

Decomposition:
- Shared package ca_pkg holds:
  - boundary mode constants BOUND_ZERO/ONE/WRAP/REFLECT;
  - state encoding IDLE/LOAD/RUN;
  - CA_WIDTH=32.
- One sub-module, ca_boundary_mux: combinational ca_left/ca_right from bound and ca_out. It is reused by future array controllers.

Test Plan:
1. Rule 90, seed 0x00010000, zeros, gens 2, gen_ready=1 → beats 0x00010000, 0x00028000, 0x00044000 on consecutive cycles; indices 0,1,2; gen_last only on index 2; gen 0 valid 2 cycles after accept.
2. Rule 90, seed 0x00000001, wrap, gens 1 → 0x00000001 then 0x80000002. The same run with zeros boundary → 0x00000001 then 0x00000002.
3. Rule 90, seed 0x00000000, ones, gens 1 → 0x00000000 then 0x80000001.
4. Test 1 with gen_ready low for 5 cycles at index 1 → gen_data held at 0x00028000 throughout; the sequence is unchanged after release; exactly 3 beats.
5. gens 0, seed 0xDEADBEEF → single beat 0xDEADBEEF with gen_last=1; cmd_ready high the next cycle.
6. gens 100, abort asserted at index 10 together with gen_ready → no transfer that cycle; busy=0 and cmd_ready=1 next cycle; a new command then runs from index 0.
